// File: rtl/zhegalkin_anf_solver.sv
// Serial truth-table to Zhegalkin (ANF) coefficient converter using an in-place Moebius butterfly.
// Optional macro DEGREE_EN adds the algebraic degree output.
module zhegalkin_anf_solver #(
    parameter int N = 4,
    localparam int SIZE = 2**N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] coef,
    output logic            busy
`ifdef DEGREE_EN
    ,
    output logic [$clog2(N+1)-1:0] degree
`endif
);

    localparam int K_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_XFORM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [SIZE-1:0] reg_q, reg_d;
    logic [SIZE-1:0] pass_res;

    // One butterfly pass over variable k: every odd-half entry absorbs its even partner.
    always_comb begin
        pass_res = reg_q;
        for (int p = 0; p < N; p++) begin
            if (k_q == K_W'(p)) begin
                for (int m = 0; m < SIZE; m++) begin
                    if (((m >> p) & 1) == 1) begin
                        pass_res[m] = reg_q[m] ^ reg_q[m & ~(1 << p)];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        reg_d   = reg_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    reg_d[idx_q] = in_bit;
                    if (idx_q == N'(SIZE - 1)) begin
                        idx_d   = '0;
                        k_d     = '0;
                        state_d = ST_XFORM;
                    end else begin
                        idx_d = idx_q + N'(1);
                    end
                end
            end
            ST_XFORM: begin
                reg_d = pass_res;
                if (k_q == K_W'(N - 1)) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
                k_d     = '0;
                reg_d   = '0;
            end
        endcase
        // Abort wins over any handshake in the same cycle.
        if (abort) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            k_d     = '0;
            reg_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            k_q     <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            reg_q   <= reg_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_XFORM) || (state_q == ST_DONE);
    assign coef      = reg_q;

`ifdef DEGREE_EN
    localparam int DEG_W = $clog2(N+1);

    logic [DEG_W-1:0] deg_max;

    always_comb begin
        deg_max = '0;
        for (int m = 0; m < SIZE; m++) begin
            if (reg_q[m] && (DEG_W'($countones(m)) > deg_max)) begin
                deg_max = DEG_W'($countones(m));
            end
        end
    end

    assign degree = deg_max;
`endif

endmodule

// File: tb/tb_zhegalkin_anf_solver.sv
// Directed self-checking bench for zhegalkin_anf_solver (N=4); degree checks only when DEGREE_EN is defined.
module tb_zhegalkin_anf_solver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_bit = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] coef;
    logic        busy;
`ifdef DEGREE_EN
    logic [2:0]  degree;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    zhegalkin_anf_solver #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef      (coef),
        .busy      (busy)
`ifdef DEGREE_EN
        ,
        .degree    (degree)
`endif
    );

    always #5 clk = ~clk;

    // Feeds all 16 bits; optional random idle gaps carry the wrong bit value on in_bit.
    task automatic load_bits(input logic [15:0] tt, input int gap_max, input logic keep_valid);
        int g;
        for (int i = 0; i < 16; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_bit   = ~tt[i];
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = tt[i];
            @(posedge clk);
        end
        #1;
        in_valid = keep_valid;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic xfer();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (coef !== 16'h0000) begin tests_failed++; $display("FAIL reset_coef got=%h exp=0000", coef); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        load_bits(16'h0AC5, 0, 0);
        tests_run++; if (in_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL basic_xform_flags got ready=%b busy=%b exp ready=0 busy=1", in_ready, busy); end
        wait_done(lat);
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        tests_run++; if (coef !== 16'h5173) begin tests_failed++; $display("FAIL basic_coef got=%h exp=5173", coef); end
`ifdef DEGREE_EN
        tests_run++; if (degree !== 3'd3) begin tests_failed++; $display("FAIL basic_degree got=%0d exp=3", degree); end
`endif
        xfer();
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_after_xfer got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_corner_tables();
        logic [15:0] tts [3];
        logic [15:0] exp_c [3];
        logic [2:0]  exp_d [3];
        int lat;
        tts[0] = 16'hFFFF; exp_c[0] = 16'h0001; exp_d[0] = 3'd0;
        tts[1] = 16'h0000; exp_c[1] = 16'h0000; exp_d[1] = 3'd0;
        tts[2] = 16'h8000; exp_c[2] = 16'h8000; exp_d[2] = 3'd4;
        for (int t = 0; t < 3; t++) begin
            load_bits(tts[t], 0, 0);
            wait_done(lat);
            tests_run++; if (out_valid !== 1'b1 || coef !== exp_c[t]) begin tests_failed++; $display("FAIL corner_coef tt=%h got=%h valid=%b exp=%h", tts[t], coef, out_valid, exp_c[t]); end
`ifdef DEGREE_EN
            tests_run++; if (degree !== exp_d[t]) begin tests_failed++; $display("FAIL corner_degree tt=%h got=%0d exp=%0d", tts[t], degree, exp_d[t]); end
`endif
            xfer();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        load_bits(16'h6996, 0, 0);
        wait_done(lat);
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (out_valid !== 1'b1 || coef !== 16'h0116) begin tests_failed++; $display("FAIL hold_cycle%0d got=%h valid=%b exp=0116 valid=1", c, coef, out_valid); end
`ifdef DEGREE_EN
            tests_run++; if (degree !== 3'd1) begin tests_failed++; $display("FAIL hold_degree got=%0d exp=1", degree); end
`endif
            @(posedge clk);
            #1;
        end
        xfer();
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_gaps();
        int lat;
        out_ready = 1'b0;
        load_bits(16'h0AC5, 3, 1);
        wait_done(lat);
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL gaps_latency got=%0d exp=4", lat); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b1 || coef !== 16'h5173) begin tests_failed++; $display("FAIL gaps_coef got=%h valid=%b exp=5173", coef, out_valid); end
        in_valid = 1'b0;
        xfer();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL gaps_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_mid_reset();
        int lat;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = (16'h0AC5 >> i) & 16'h1;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (coef !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_state got coef=%h ready=%b busy=%b valid=%b exp 0000/1/0/0", coef, in_ready, busy, out_valid); end
        #2 rst = 1'b0;
        out_ready = 1'b1;
        load_bits(16'h0AC5, 0, 0);
        wait_done(lat);
        tests_run++; if (coef !== 16'h5173 || lat !== 4) begin tests_failed++; $display("FAIL midrst_reload got=%h lat=%0d exp=5173 lat=4", coef, lat); end
        xfer();
    endtask

    task automatic test_abort();
        int lat;
        out_ready = 1'b1;
        load_bits(16'h0AC5, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_pre got busy=%b valid=%b exp 1/0", busy, out_valid); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        tests_run++; if (coef !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_state got coef=%h ready=%b busy=%b valid=%b exp 0000/1/0/0", coef, in_ready, busy, out_valid); end
        load_bits(16'h0AC5, 0, 0);
        wait_done(lat);
        tests_run++; if (coef !== 16'h5173 || lat !== 4) begin tests_failed++; $display("FAIL abort_reload got=%h lat=%0d exp=5173 lat=4", coef, lat); end
        xfer();
    endtask

    task automatic test_round_trip();
        logic [15:0] tt;
        logic [15:0] c;
        int lat;
        out_ready = 1'b0;
        for (int r = 0; r < 20; r++) begin
            tt = 16'($urandom);
            load_bits(tt, 0, 0);
            wait_done(lat);
            c = coef;
            xfer();
            load_bits(c, 0, 0);
            wait_done(lat);
            tests_run++; if (out_valid !== 1'b1 || coef !== tt) begin tests_failed++; $display("FAIL roundtrip%0d got=%h valid=%b exp=%h", r, coef, out_valid, tt); end
            xfer();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner_tables();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        test_abort();
        test_round_trip();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
